// File: rtl/poly_sequencer.sv
// rtl/poly_sequencer.sv - go-stepped operand loader and fixed five-cycle C*x*x+B*x+A datapath sequencer
module poly_sequencer (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    output logic       load_a,
    output logic       load_b,
    output logic       load_c,
    output logic       load_x,
    output logic       load_alu_out,
    output logic       load_r,
    output logic [1:0] alu_select_a,
    output logic [1:0] alu_select_b,
    output logic       alu_op,
    output logic       busy,
    output logic       done
);

    typedef enum logic [4:0] {
        LOAD_A      = 5'd0,
        LOAD_A_WAIT = 5'd1,
        LOAD_B      = 5'd2,
        LOAD_B_WAIT = 5'd3,
        LOAD_C      = 5'd4,
        LOAD_C_WAIT = 5'd5,
        LOAD_X      = 5'd6,
        LOAD_X_WAIT = 5'd7,
        CYC0        = 5'd8,
        CYC1        = 5'd9,
        CYC2        = 5'd10,
        CYC3        = 5'd11,
        CYC4        = 5'd12,
        DONE        = 5'd13,
        DONE_WAIT   = 5'd14
    } state_t;

    typedef struct packed {
        logic       load_a;
        logic       load_b;
        logic       load_c;
        logic       load_x;
        logic       load_alu_out;
        logic       load_r;
        logic [1:0] sel_a;
        logic [1:0] sel_b;
        logic       alu_op;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    state_t state;
    ctrl_t  ctrl;

    // Each press/release pair is one advance: the WAIT states absorb a held go.
    function automatic state_t next_state(input state_t s, input logic g);
        case (s)
            LOAD_A:      return g ? LOAD_A_WAIT : LOAD_A;
            LOAD_A_WAIT: return g ? LOAD_A_WAIT : LOAD_B;
            LOAD_B:      return g ? LOAD_B_WAIT : LOAD_B;
            LOAD_B_WAIT: return g ? LOAD_B_WAIT : LOAD_C;
            LOAD_C:      return g ? LOAD_C_WAIT : LOAD_C;
            LOAD_C_WAIT: return g ? LOAD_C_WAIT : LOAD_X;
            LOAD_X:      return g ? LOAD_X_WAIT : LOAD_X;
            LOAD_X_WAIT: return g ? LOAD_X_WAIT : CYC0;
            CYC0:        return CYC1;
            CYC1:        return CYC2;
            CYC2:        return CYC3;
            CYC3:        return CYC4;
            CYC4:        return DONE;
            DONE:        return g ? DONE_WAIT : DONE;
            DONE_WAIT:   return g ? DONE_WAIT : LOAD_A;
            default:     return LOAD_A;
        endcase
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD_A: c.load_a = 1'b1;
            LOAD_B: c.load_b = 1'b1;
            LOAD_C: c.load_c = 1'b1;
            LOAD_X: c.load_x = 1'b1;
            CYC0, CYC1: begin
                c.load_c       = 1'b1;
                c.load_alu_out = 1'b1;
                c.sel_a        = SEL_C;
                c.sel_b        = SEL_X;
                c.alu_op       = 1'b1;
                c.busy         = 1'b1;
            end
            CYC2: begin
                c.load_b       = 1'b1;
                c.load_alu_out = 1'b1;
                c.sel_a        = SEL_B;
                c.sel_b        = SEL_X;
                c.alu_op       = 1'b1;
                c.busy         = 1'b1;
            end
            CYC3: begin
                c.load_a       = 1'b1;
                c.load_alu_out = 1'b1;
                c.sel_a        = SEL_A;
                c.sel_b        = SEL_B;
                c.busy         = 1'b1;
            end
            CYC4: begin
                c.load_r = 1'b1;
                c.sel_a  = SEL_A;
                c.sel_b  = SEL_C;
                c.busy   = 1'b1;
            end
            DONE, DONE_WAIT: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered from the next state so they stay a pure decode of state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= LOAD_A;
            ctrl  <= decode(LOAD_A);
        end else begin
            state <= next_state(state, go);
            ctrl  <= decode(next_state(state, go));
        end
    end

    assign load_a       = ctrl.load_a;
    assign load_b       = ctrl.load_b;
    assign load_c       = ctrl.load_c;
    assign load_x       = ctrl.load_x;
    assign load_alu_out = ctrl.load_alu_out;
    assign load_r       = ctrl.load_r;
    assign alu_select_a = ctrl.sel_a;
    assign alu_select_b = ctrl.sel_b;
    assign alu_op       = ctrl.alu_op;
    assign busy         = ctrl.busy;
    assign done         = ctrl.done;

endmodule

// File: tb/tb_poly_sequencer.sv
// tb/tb_poly_sequencer.sv - directed bench for poly_sequencer driving a behavioural 8-bit datapath
module tb_poly_sequencer;

    logic       clk;
    logic       resetn;
    logic       go;
    logic       load_a, load_b, load_c, load_x, load_alu_out, load_r;
    logic [1:0] alu_select_a, alu_select_b;
    logic       alu_op, busy, done;

    logic [7:0] data_in;
    logic [7:0] ra, rb, rc, rx, rr;
    logic [7:0] sa, sb, alu_out;
    int         load_r_count;

    int checks   = 0;
    int failures = 0;

    poly_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .go           (go),
        .load_a       (load_a),
        .load_b       (load_b),
        .load_c       (load_c),
        .load_x       (load_x),
        .load_alu_out (load_alu_out),
        .load_r       (load_r),
        .alu_select_a (alu_select_a),
        .alu_select_b (alu_select_b),
        .alu_op       (alu_op),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] a,
                                        input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return x;
        endcase
    endfunction

    always_comb begin
        sa      = pick(alu_select_a, ra, rb, rc, rx);
        sb      = pick(alu_select_b, ra, rb, rc, rx);
        alu_out = alu_op ? sa * sb : sa + sb;
    end

    always_ff @(posedge clk) begin
        if (load_a) ra <= load_alu_out ? alu_out : data_in;
        if (load_b) rb <= load_alu_out ? alu_out : data_in;
        if (load_c) rc <= load_alu_out ? alu_out : data_in;
        if (load_x) rx <= data_in;
        if (load_r) begin
            rr           <= alu_out;
            load_r_count <= load_r_count + 1;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] val);
        data_in = val;
        go      = 1'b1;
        step();
        chk("wait_no_loads", {load_a, load_b, load_c, load_x, busy, done}, 6'b0);
        go = 1'b0;
        step();
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] x, input logic [7:0] exp_r, input bit long_b);
        int nb;
        int bcnt;
        int rpos;
        chk("in_load_a", load_a, 1'b1);
        press(a);
        chk("in_load_b", load_b, 1'b1);
        if (long_b) begin
            data_in = b;
            go      = 1'b1;
            nb      = 0;
            repeat (20) begin
                step();
                if (load_b) nb++;
            end
            chk("long_press_load_b", nb, 0);
            chk("long_press_state", {load_a, load_b, load_c, load_x}, 4'b0000);
            go = 1'b0;
            step();
            chk("long_press_b_value", rb, b);
        end else begin
            press(b);
        end
        chk("in_load_c", load_c, 1'b1);
        press(c);
        chk("in_load_x", load_x, 1'b1);
        press(x);
        bcnt = 0;
        rpos = -1;
        for (int i = 0; i < 12; i++) begin
            if (busy) bcnt++;
            if (load_r) rpos = i;
            if (done) break;
            step();
        end
        chk("busy_cycles", bcnt, 5);
        chk("load_r_latency", rpos, 4);
        chk("done_after_run", done, 1'b1);
        chk("result_r", rr, exp_r);
    endtask

    task automatic restart_from_done();
        go = 1'b1;
        step();
        chk("done_wait_done", {done, busy}, 2'b10);
        go = 1'b0;
        step();
        chk("restart_load_a", {load_a, done}, 2'b10);
    endtask

    initial begin
        int rc0;
        resetn  = 1'b0;
        go      = 1'b1;
        data_in = 8'h00;
        load_r_count = 0;
        step();
        step();
        chk("reset_outputs", {load_a, load_b, load_c, load_x, load_alu_out, load_r,
                              alu_select_a, alu_select_b, alu_op, busy, done}, 15'b100000_0000_000);
        resetn = 1'b1;
        go     = 1'b0;
        step();
        chk("idle_load_a", load_a, 1'b1);

        run(8'd1, 8'd2, 8'd3, 8'd4, 8'h39, 1'b1);
        restart_from_done();
        run(8'd0, 8'd0, 8'd255, 8'd2, 8'hFC, 1'b0);
        restart_from_done();

        // Abort a compute in CYC2 and confirm the result register is never written.
        press(8'd9);
        press(8'd9);
        press(8'd9);
        press(8'd9);
        rc0 = load_r_count;
        step();
        step();
        chk("cyc2_signature", {load_b, load_alu_out, alu_select_a, alu_select_b, alu_op, busy},
            8'b11_01_11_1_1);
        resetn = 1'b0;
        go     = 1'b1;
        step();
        chk("midreset_state", {load_a, busy, done, load_r}, 4'b1000);
        resetn = 1'b1;
        go     = 1'b0;
        repeat (8) step();
        chk("midreset_no_load_r", load_r_count - rc0, 0);
        chk("midreset_idle", {load_a, busy}, 2'b10);

        run(8'd5, 8'd7, 8'd9, 8'd3, 8'h6B, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
